// File: rtl/svc_axi_pkg.sv
// AXI response codes shared by the svc AXI-Lite subordinate blocks.
package svc_axi_pkg;

    typedef logic [1:0] axi_resp_t;

    localparam axi_resp_t RESP_OKAY   = 2'b00;
    localparam axi_resp_t RESP_SLVERR = 2'b10;

endpackage

// File: rtl/svc_axil_rd_resp_fifo.sv
// Circular response buffer holding {rdata, rresp} beats until the manager takes them.
module svc_axil_rd_resp_fifo #(
    parameter int DEPTH = 3,
    parameter int WIDTH = 18
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // An empty buffer presents zero data with an OKAY code rather than a stale slot.
    assign head_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assert property (@(posedge clk) disable iff (!rst_n) !(push && full && !do_pop));

endmodule

// File: rtl/svc_axil_sram_rd.sv
// AXI-Lite read subordinate in front of a fixed-latency synchronous SRAM read port.
module svc_axil_sram_rd
    import svc_axi_pkg::*;
#(
    parameter int AXIL_ADDR_WIDTH = 8,
    parameter int AXIL_DATA_WIDTH = 16,
    parameter int MEM_WORDS       = 64,
    parameter int RD_LATENCY      = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         s_axil_arvalid,
    input  logic [AXIL_ADDR_WIDTH-1:0]   s_axil_araddr,
    output logic                         s_axil_arready,
    output logic                         s_axil_rvalid,
    output logic [AXIL_DATA_WIDTH-1:0]   s_axil_rdata,
    output logic [1:0]                   s_axil_rresp,
    input  logic                         s_axil_rready,
    output logic                         sram_rd_en,
    output logic [$clog2(MEM_WORDS)-1:0] sram_rd_addr,
    input  logic [AXIL_DATA_WIDTH-1:0]   sram_rd_data
);

    localparam int DEPTH  = RD_LATENCY + 2;
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int OFF_W  = $clog2(AXIL_DATA_WIDTH / 8);
    localparam int IDX_W  = $clog2(MEM_WORDS);
    localparam int CMP_W  = (AXIL_ADDR_WIDTH > 32) ? AXIL_ADDR_WIDTH + 1 : 33;
    localparam int FIFO_W = AXIL_DATA_WIDTH + 2;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
    localparam logic [CMP_W-1:0] MEM_WORDS_W = CMP_W'(MEM_WORDS);

    logic                       ar_hs;
    logic                       r_hs;
    logic                       in_range;
    logic [AXIL_ADDR_WIDTH-1:0] idx;
    logic [CNT_W-1:0]           cnt;
    logic [CNT_W-1:0]           cnt_next;
    logic [RD_LATENCY-1:0]      pipe_valid;
    logic [RD_LATENCY-1:0]      pipe_err;
    logic                       tail_valid;
    logic                       tail_err;
    logic [FIFO_W-1:0]          push_data;
    logic [FIFO_W-1:0]          head_data;
    logic                       fifo_full;
    logic                       fifo_empty;

    assign ar_hs = s_axil_arvalid && s_axil_arready;
    assign r_hs  = s_axil_rvalid && s_axil_rready;

    // Widened compare so large byte addresses can never alias back into the array.
    assign idx          = s_axil_araddr >> OFF_W;
    assign in_range     = (CMP_W'(idx) < MEM_WORDS_W);
    assign sram_rd_en   = ar_hs && in_range;
    assign sram_rd_addr = idx[IDX_W-1:0];

    always_comb begin
        cnt_next = cnt;
        if (ar_hs && !r_hs) begin
            cnt_next = cnt + CNT_W'(1);
        end else if (r_hs && !ar_hs) begin
            cnt_next = cnt - CNT_W'(1);
        end
    end

    // Credits cover in-flight plus buffered beats, so arready never waits on rready combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt            <= '0;
            s_axil_arready <= 1'b0;
        end else begin
            cnt            <= cnt_next;
            s_axil_arready <= (cnt_next < DEPTH_CNT);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_valid <= '0;
            pipe_err   <= '0;
        end else begin
            pipe_valid[0] <= ar_hs;
            pipe_err[0]   <= !in_range;
            for (int i = 1; i < RD_LATENCY; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_err[i]   <= pipe_err[i-1];
            end
        end
    end

    assign tail_valid = pipe_valid[RD_LATENCY-1];
    assign tail_err   = pipe_err[RD_LATENCY-1];
    assign push_data  = tail_err ? {AXIL_DATA_WIDTH'(0), RESP_SLVERR}
                                 : {sram_rd_data, RESP_OKAY};

    svc_axil_rd_resp_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (FIFO_W)
    ) u_resp_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (tail_valid),
        .push_data (push_data),
        .pop       (r_hs),
        .head_data (head_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign s_axil_rvalid                = !fifo_empty;
    assign {s_axil_rdata, s_axil_rresp} = head_data;

    assert property (@(posedge clk) disable iff (!rst_n) !(tail_valid && fifo_full && !r_hs));

endmodule

// File: doc/svc_axil_sram_rd.md
Name: svc_axil_sram_rd

Overview:
AXI-Lite read subordinate that terminates the AXI-Lite read manager port of the AXI-to-AXI-Lite read adapter and drives a synchronous SRAM read port with fixed latency.
It converts byte addresses to word indices and pipelines SRAM reads. An internal response FIFO, sized from a credit count, sustains one read beat per clock under R backpressure with no combinational rready-to-arready path.
Out-of-range addresses return SLVERR without touching the SRAM.

Parameters:
AXIL_ADDR_WIDTH, 8, AXI-Lite byte address width.
AXIL_DATA_WIDTH, 16, data width in bits; power of two, at least 8.
MEM_WORDS, 64, SRAM depth in words; indices at or above this are out of range.
RD_LATENCY, 1, SRAM read latency in cycles from sram_rd_en to valid sram_rd_data; legal values 1 to 3.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
s_axil_arvalid  in  1  read address valid
s_axil_araddr  in  AXIL_ADDR_WIDTH  read byte address
s_axil_arready  out  1  read address ready (registered)
s_axil_rvalid  out  1  read data valid
s_axil_rdata  out  AXIL_DATA_WIDTH  read data
s_axil_rresp  out  2  read response (OKAY or SLVERR)
s_axil_rready  in  1  read data ready
sram_rd_en  out  1  SRAM read strobe
sram_rd_addr  out  $clog2(MEM_WORDS)  SRAM word index
sram_rd_data  in  AXIL_DATA_WIDTH  SRAM read data, valid RD_LATENCY cycles after sram_rd_en

Behaviour:
- Reset (async assert on rst_n low, sync deassert): s_axil_arready=0, s_axil_rvalid=0, s_axil_rdata=0, s_axil_rresp=OKAY, sram_rd_en=0. Credit count, pipeline valid bits and FIFO are cleared.
- Reset mid-operation: all in-flight and buffered responses are dropped. No R beat is emitted for them after reset.
- Local constant DEPTH = RD_LATENCY+2.
- Credit count cnt, range 0..DEPTH:
  - increments on an AR handshake;
  - decrements on an R handshake;
  - unchanged when both occur in the same cycle.
- s_axil_arready is a register loaded each cycle with (cnt_next < DEPTH). It is never a function of s_axil_rready in the same cycle.
- Word index idx = araddr >> $clog2(AXIL_DATA_WIDTH/8). Misaligned low bits are ignored.
- in_range = (idx < MEM_WORDS), compared at full address width with no truncation before the compare.
- AR handshake with in_range: sram_rd_en=1 and sram_rd_addr=idx in the same cycle (combinational from arvalid&&arready).
- AR handshake with !in_range: sram_rd_en=0. The request still occupies a pipeline slot and a credit.
- Tag pipeline: RD_LATENCY stages of {valid, err}. The tail stage is aligned to sram_rd_data.
- At the tail, if valid: push {err ? 0 : sram_rd_data, err ? SLVERR : OKAY} into the FIFO.
- Latency: an AR handshake in cycle t gives s_axil_rvalid=1 from cycle t+RD_LATENCY+1 at the earliest.
- R outputs come from the FIFO head: rvalid = !empty. rdata and rresp are stable while rvalid && !rready.
- FIFO never overflows because cnt bounds total in-flight plus buffered entries to DEPTH. Overflow is an assertion failure.
- Simultaneous FIFO push and pop: legal when full or empty. Pop of a 1-entry FIFO with a push in the same cycle gives the new entry next cycle.
- Responses are returned strictly in AR acceptance order.
- Throughput: with rready held at 1 and arvalid held at 1, one AR and one R handshake per cycle in steady state.

Decomposition:
- svc_axi_pkg holds the RESP_OKAY=2'b00 and RESP_SLVERR=2'b10 constants.
- One sub-module, svc_axil_rd_resp_fifo: a synchronous FIFO of DEPTH entries with width AXIL_DATA_WIDTH+2, with full/empty flags and an async active-low reset.
- Credit counter, tag pipeline and address decode stay in the top module.

Test Plan:
1. Single read: MEM word 5 = 16'hBEEF, araddr=8'h0A, RD_LATENCY=1 -> sram_rd_addr=5 in the handshake cycle; rvalid 2 cycles later with rdata=16'hBEEF, rresp=2'b00.
2. Out of range: araddr=8'h80 (idx 64) -> sram_rd_en never asserted; rdata=0, rresp=2'b10.
3. Streaming: arvalid and rready held high, 16 reads of idx 0..15 (word i = i+16'h100) -> 16 consecutive R beats in order, one per cycle after the first, arready never drops.
4. Backpressure: rready=0 with arvalid held -> exactly DEPTH=3 ARs accepted, then arready=0. Raise rready -> 3 beats in order, arready returns the cycle after the first R handshake.
5. Latency sweep: RD_LATENCY=3 -> first rvalid 4 cycles after the AR handshake; DEPTH=5 ARs accepted under full stall.
6. Reset mid-burst: rst_n low for 1 cycle with 2 responses buffered -> rvalid=0 immediately and arready=0. After release no stale beats appear; the next read returns correct data.
